// File: rtl/aqp_sync_bit.sv
// Single-bit synchroniser: SYNC_STAGES flop chain plus one history flop so the
// parent can detect edges as (q != q_hist) without re-sampling the async input.
module aqp_sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_hist
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // shift the raw input through the chain; history trails the last stage by one clk
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // chain and history come out of reset at the line's idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q      = sync_q[SYNC_STAGES-1];
  assign q_hist = hist_q;

endmodule

// File: rtl/aqp_esp_spi_phy.sv
// ESP32 SPI slave front-end (mode 0, MSB first). Oversamples ssel_n/sclk/mosi in
// clk, frames messages, assembles rx bytes and shifts tx bytes out on miso.
module aqp_esp_spi_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       esp_ssel_n,
  input  logic       esp_sclk,
  input  logic       esp_mosi,
  output logic       esp_miso,
  output logic       msg_start,
  output logic       msg_end,
  output logic       msg_trunc,
  output logic [7:0] rxdata,
  output logic       rxdata_valid,
  input  logic [7:0] txdata,
  output logic       txdata_ack
);

  // Synced ssel_n is only trusted once the chain has flushed its reset value,
  // otherwise the reset-time 1 would arm us during a message already in progress.
  localparam logic [7:0] WARM_MAX = 8'(SYNC_STAGES);

  logic ssel_cur, ssel_hist, sclk_cur, sclk_hist, mosi_cur, mosi_hist_unused;

  aqp_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .reset(reset), .d(esp_ssel_n), .q(ssel_cur), .q_hist(ssel_hist));
  aqp_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(esp_sclk), .q(sclk_cur), .q_hist(sclk_hist));
  aqp_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(esp_mosi), .q(mosi_cur), .q_hist(mosi_hist_unused));

  logic ssel_fall, ssel_rise, sclk_rise, sclk_fall;
  assign ssel_fall = ssel_hist & ~ssel_cur;
  assign ssel_rise = ~ssel_hist & ssel_cur;
  assign sclk_rise = ~sclk_hist & sclk_cur;
  assign sclk_fall = sclk_hist & ~sclk_cur;

  logic [7:0] warm_q, warm_d;
  logic       armed_q, armed_d;
  logic       active_q, active_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rxv_q, rxv_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       trunc_q, trunc_d;
  logic       ack_q, ack_d;

  // framing, rx assembly and tx shifting; an ssel edge pre-empts any sclk edge in the same clk
  always_comb begin
    warm_d     = (warm_q == WARM_MAX) ? warm_q : warm_q + 8'd1;
    armed_d    = armed_q | ((warm_q == WARM_MAX) & ssel_cur);
    active_d   = active_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rxdata_d   = rxdata_q;
    rxv_d      = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    trunc_d    = 1'b0;
    ack_d      = 1'b0;
    if (ssel_fall && armed_q) begin
      active_d   = 1'b1;
      bit_cnt_d  = 3'd0;
      tx_shift_d = txdata;
      ack_d      = 1'b1;
      start_d    = 1'b1;
    end else if (ssel_rise && active_q) begin
      // partial byte is simply dropped; only the trunc flag records it
      active_d   = 1'b0;
      end_d      = 1'b1;
      trunc_d    = (bit_cnt_q != 3'd0);
      bit_cnt_d  = 3'd0;
      tx_shift_d = 8'hFF;
    end else if (active_q) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[5:0], mosi_cur};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rxdata_d = {rx_shift_q, mosi_cur};
          rxv_d    = 1'b1;
        end
      end else if (sclk_fall) begin
        // bit 7 of a fresh byte is presented by the load itself, so a boundary
        // fall reloads while every other fall advances to the next bit
        if (bit_cnt_q == 3'd0) begin
          tx_shift_d = txdata;
          ack_d      = 1'b1;
        end else begin
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
      end
    end
  end

  // state and registered outputs; reset abandons any message without a msg_end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q     <= 8'd0;
      armed_q    <= 1'b0;
      active_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 8'hFF;
      rxdata_q   <= 8'd0;
      rxv_q      <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      trunc_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      warm_q     <= warm_d;
      armed_q    <= armed_d;
      active_q   <= active_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rxdata_q   <= rxdata_d;
      rxv_q      <= rxv_d;
      start_q    <= start_d;
      end_q      <= end_d;
      trunc_q    <= trunc_d;
      ack_q      <= ack_d;
    end
  end

  assign esp_miso     = active_q ? tx_shift_q[7] : 1'b1;
  assign msg_start    = start_q;
  assign msg_end      = end_q;
  assign msg_trunc    = trunc_q;
  assign rxdata       = rxdata_q;
  assign rxdata_valid = rxv_q;
  assign txdata_ack   = ack_q;

endmodule

// File: tb/tb_aqp_esp_spi_phy.sv
// Bench for aqp_esp_spi_phy: an SPI master at fclk/8 plus a consumer that
// refreshes txdata after each received byte; expectations come from the
// message-level rules (bytes in = bytes out, one tx byte per slot, etc.).
module tb_aqp_esp_spi_phy;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       esp_ssel_n = 1'b1;
  logic       esp_sclk = 1'b0;
  logic       esp_mosi = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       esp_miso, msg_start, msg_end, msg_trunc, rxdata_valid, txdata_ack;
  logic [7:0] rxdata;

  aqp_esp_spi_phy #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .esp_ssel_n(esp_ssel_n), .esp_sclk(esp_sclk),
    .esp_mosi(esp_mosi), .esp_miso(esp_miso), .msg_start(msg_start),
    .msg_end(msg_end), .msg_trunc(msg_trunc), .rxdata(rxdata),
    .rxdata_valid(rxdata_valid), .txdata(txdata), .txdata_ack(txdata_ack));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // event monitor, sampled mid-cycle
  int n_start = 0, n_end = 0, n_trunc = 0, n_ack = 0, n_rxv = 0, n_badtrunc = 0;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (msg_start) n_start++;
    if (msg_end) n_end++;
    if (msg_end && msg_trunc) n_trunc++;
    if (msg_trunc && !msg_end) n_badtrunc++;
    if (txdata_ack) n_ack++;
    if (rxdata_valid) begin
      n_rxv++;
      rx_q.push_back(rxdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] mo_q[$];    // bytes the master sends
  logic [7:0] resp_q[$];  // tx byte for slot k+1, written 2 clk after the k+1th rxdata_valid
  logic       mi_bits[$]; // miso as seen by the master at each rising sclk

  // one message of nbits; ssel_n rises together with the final sclk fall
  task automatic msg(input string tag, input int nbits, input logic [7:0] tx_first);
    int s0, e0, t0, a0, r0, q0, slots, nb, w;
    logic [7:0] obs, exp, mask;
    s0 = n_start; e0 = n_end; t0 = n_trunc; a0 = n_ack; r0 = n_rxv; q0 = rx_q.size();
    slots = (nbits + 7) / 8;
    mi_bits.delete();
    txdata = tx_first;
    @(negedge clk);
    esp_ssel_n = 1'b0;
    clks(4);
    fork
      begin
        for (int b = 0; b < nbits; b++) begin
          esp_mosi = mo_q[b/8][7-(b%8)];
          clks(4);
          mi_bits.push_back(esp_miso);
          esp_sclk = 1'b1;
          clks(4);
          if (b != nbits - 1) esp_sclk = 1'b0;
        end
        esp_sclk = 1'b0;
        esp_ssel_n = 1'b1;
      end
      begin
        for (int k = 0; k < resp_q.size(); k++) begin
          w = 0;
          while (n_rxv < r0 + k + 1 && w < 2000) begin
            clks(1);
            w++;
          end
          if (w >= 2000) chk({tag, "_rxv_wait"}, n_rxv, r0 + k + 1);
          clks(2);
          txdata = resp_q[k];
        end
      end
    join
    clks(8);
    chk({tag, "_start"}, n_start - s0, 1);
    chk({tag, "_end"}, n_end - e0, 1);
    chk({tag, "_trunc"}, n_trunc - t0, (nbits % 8) != 0);
    chk({tag, "_ack"}, n_ack - a0, slots);
    chk({tag, "_rxv"}, n_rxv - r0, nbits / 8);
    for (int i = 0; i < nbits / 8; i++)
      if (q0 + i < rx_q.size()) chk({tag, "_rxbyte"}, rx_q[q0 + i], mo_q[i]);
    for (int s = 0; s < slots; s++) begin
      nb = (nbits - s * 8 >= 8) ? 8 : nbits - s * 8;
      obs = 8'h00;
      for (int j = 0; j < nb; j++) obs[7-j] = mi_bits[s*8 + j];
      mask = 8'hFF << (8 - nb);
      exp = ((s == 0) ? tx_first : resp_q[s-1]) & mask;
      chk({tag, "_miso"}, obs, exp);
    end
    chk({tag, "_miso_idle"}, esp_miso, 1'b1);
  endtask

  int s0, e0, a0, r0, bad, nbytes, part, nbits, slots;
  logic [7:0] tmp;

  initial begin
    // reset state
    clks(3);
    chk("rst_miso", esp_miso, 1'b1);
    chk("rst_outs", {msg_start, msg_end, msg_trunc, rxdata_valid, txdata_ack}, 5'b0);
    chk("rst_rxdata", rxdata, 8'h00);
    reset = 1'b0;
    clks(10);
    chk("post_rst_quiet", n_start + n_end + n_ack + n_rxv, 0);

    // single byte
    mo_q = '{8'hA5}; resp_q = '{};
    msg("t1", 8, 8'($urandom));
    chk("t1_hold", rxdata, 8'hA5);

    // tx reload at the byte boundary
    mo_q = '{8'($urandom), 8'($urandom)}; resp_q = '{8'h81};
    msg("t2", 16, 8'h3C);

    // read-style message: the reply byte is supplied late
    mo_q = '{8'h23, 8'h34, 8'h12, 8'h00}; resp_q = '{8'($urandom), 8'($urandom), 8'h5A};
    msg("t3", 32, 8'($urandom));

    // truncated message, then a clean one
    mo_q = '{8'($urandom)}; resp_q = '{};
    msg("t4a", 5, 8'($urandom));
    mo_q = '{8'h01}; resp_q = '{};
    msg("t4b", 8, 8'($urandom));

    // reset in the middle of a byte with ssel held low
    txdata = 8'h11;
    esp_ssel_n = 1'b0;
    clks(4);
    for (int b = 0; b < 5; b++) begin
      esp_mosi = 1'($urandom);
      clks(4); esp_sclk = 1'b1; clks(4); esp_sclk = 1'b0;
    end
    reset = 1'b1;
    clks(3);
    chk("t5_rst_miso", esp_miso, 1'b1);
    chk("t5_rst_rxdata", rxdata, 8'h00);
    reset = 1'b0;
    s0 = n_start; e0 = n_end; a0 = n_ack; r0 = n_rxv;
    clks(10);
    for (int b = 0; b < 8; b++) begin
      esp_mosi = 1'($urandom);
      clks(4); esp_sclk = 1'b1; clks(4); esp_sclk = 1'b0;
    end
    clks(6);
    chk("t5_no_start", n_start - s0, 0);
    chk("t5_no_rxv", n_rxv - r0, 0);
    chk("t5_no_ack", n_ack - a0, 0);
    esp_ssel_n = 1'b1;
    clks(8);
    chk("t5_no_end", n_end - e0, 0);
    mo_q = '{8'hFF}; resp_q = '{};
    msg("t5", 8, 8'($urandom));

    // sclk/mosi activity with ssel high
    s0 = n_start; e0 = n_end; a0 = n_ack; r0 = n_rxv; bad = 0;
    for (int b = 0; b < 16; b++) begin
      esp_mosi = 1'($urandom);
      clks(4);
      if (esp_miso !== 1'b1) bad++;
      esp_sclk = 1'b1;
      clks(4);
      if (esp_miso !== 1'b1) bad++;
      esp_sclk = 1'b0;
    end
    clks(6);
    chk("t6_events", (n_start - s0) + (n_end - e0) + (n_ack - a0) + (n_rxv - r0), 0);
    chk("t6_miso", bad, 0);

    // random messages, some truncated
    for (int m = 0; m < 5; m++) begin
      nbytes = $urandom_range(1, 3);
      part = $urandom_range(0, 7);
      nbits = nbytes * 8 + part;
      slots = (nbits + 7) / 8;
      mo_q.delete(); resp_q.delete();
      for (int i = 0; i < slots; i++) begin
        tmp = 8'($urandom);
        mo_q.push_back(tmp);
      end
      for (int i = 0; i < slots - 1; i++) begin
        tmp = 8'($urandom);
        resp_q.push_back(tmp);
      end
      msg("rnd", nbits, 8'($urandom));
    end

    chk("trunc_without_end", n_badtrunc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
